// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with trap/mret sequencing, redirect PC and mcycle/minstret counters
module csr_file_m #(
  parameter int XLEN = 32,
  parameter int CNT_W = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret,
  input  logic [XLEN-1:0] next_pc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  input  logic            instr_retire,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);
  localparam int HW = CNT_W - XLEN;
  localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED_EN ? ~XLEN'(2) : ~XLEN'(3);
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
  localparam logic [XLEN-1:0] EPC_MASK = ~XLEN'(3);
  logic st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [XLEN-1:0] mstatus, mip, pend, base, wval;
  logic impl, wr_try, illegal, int_req, act, take_exc, take_mret, take_int, we;
  logic [3:0] int_code;
  always_comb begin
    mstatus = '0;
    mstatus[12:11] = 2'b11;
    mstatus[7] = st_mpie_q;
    mstatus[3] = st_mie_q;
    mip = '0;
    mip[3] = irq_sw;
    mip[7] = irq_timer;
    mip[11] = irq_ext;
    pend = mip & mie_q;
    int_req = st_mie_q & |pend;
    int_code = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
    take_exc = exc_valid;
    take_mret = ~exc_valid & mret;
    take_int = ~exc_valid & ~mret & int_req;
    act = exc_valid | mret | int_req;
    base = mtvec_q & ~XLEN'(3);
    redirect = ~rst & act;
    redirect_pc = take_exc ? base : take_mret ? mepc_q :
                  mtvec_q[0] ? base + (XLEN'(int_code) << 2) : base;
    impl = 1'b1;
    case (csr_addr)
      12'h300: csr_rdata = mstatus;
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h344: csr_rdata = mip;
      12'hB00: csr_rdata = mcycle_q[XLEN-1:0];
      12'hB80: csr_rdata = XLEN'(mcycle_q[CNT_W-1:XLEN]);
      12'hB02: csr_rdata = minstret_q[XLEN-1:0];
      12'hB82: csr_rdata = XLEN'(minstret_q[CNT_W-1:XLEN]);
      default: begin
        csr_rdata = '0;
        impl = 1'b0;
      end
    endcase
    // RS/RC with a zero operand is a pure read and never counts as a write attempt
    wr_try = (csr_op == 2'b01) | (csr_wdata != '0);
    illegal = (csr_op != 2'b00) & (~impl | ((csr_addr == 12'h344) & wr_try));
    csr_illegal = ~rst & illegal;
    we = (csr_op != 2'b00) & wr_try & ~illegal & ~act;
    wval = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? csr_rdata | csr_wdata : csr_rdata & ~csr_wdata;
    st_mie_d = st_mie_q;
    st_mpie_d = st_mpie_q;
    mie_d = mie_q;
    mtvec_d = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    mcycle_d = mcycle_q + CNT_W'(1);
    minstret_d = minstret_q + CNT_W'(instr_retire & ~exc_valid);
    if (we)
      case (csr_addr)
        12'h300: begin
          st_mie_d = wval[3];
          st_mpie_d = wval[7];
        end
        12'h304: mie_d = wval & MIE_MASK;
        12'h305: mtvec_d = wval & MTVEC_MASK;
        12'h340: mscratch_d = wval;
        12'h341: mepc_d = wval & EPC_MASK;
        12'h342: mcause_d = wval;
        12'hB00: mcycle_d = {mcycle_q[CNT_W-1:XLEN], wval};
        12'hB80: mcycle_d = {wval[HW-1:0], mcycle_q[XLEN-1:0]};
        12'hB02: minstret_d = {minstret_q[CNT_W-1:XLEN], wval};
        12'hB82: minstret_d = {wval[HW-1:0], minstret_q[XLEN-1:0]};
        default: ;
      endcase
    if (take_exc | take_int) begin
      mepc_d = (take_exc ? exc_pc : next_pc) & EPC_MASK;
      mcause_d = take_exc ? XLEN'(exc_cause) : {1'b1, (XLEN-1)'(int_code)};
      st_mpie_d = st_mie_q;
      st_mie_d = 1'b0;
    end
    if (take_mret) begin
      st_mie_d = st_mpie_q;
      st_mpie_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_mie_q <= 1'b0;
      st_mpie_q <= 1'b0;
      mie_q <= '0;
      mtvec_q <= MTVEC_RST & MTVEC_MASK;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mcycle_q <= '0;
      minstret_q <= '0;
    end else begin
      st_mie_q <= st_mie_d;
      st_mpie_q <= st_mpie_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
    end
endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed and randomized checks of csr_file_m against a spec-level reference model
module tb_csr_file_m;
  logic clk = 0, rst = 1;
  logic [1:0] csr_op = 0;
  logic [11:0] csr_addr = 0;
  logic [31:0] csr_wdata = 0, csr_rdata, exc_pc = 0, next_pc = 0, redirect_pc;
  logic csr_illegal, exc_valid = 0, mret = 0, irq_ext = 0, irq_timer = 0, irq_sw = 0;
  logic instr_retire = 0, redirect;
  logic [3:0] exc_cause = 0;
  int checks = 0, errors = 0;
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;
  logic [11:0] addr_tab [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h301};
  csr_file_m dut (.clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .mret(mret), .next_pc(next_pc), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_sw(irq_sw), .instr_retire(instr_retire), .redirect(redirect), .redirect_pc(redirect_pc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_cyc = 0; m_ins = 0;
  endtask
  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op = op; csr_addr = a; csr_wdata = d;
  endtask
  // One clock of the core: predict outputs from the model, compare, clock, advance the model.
  task automatic step();
    logic [31:0] mip, rd, nv, pend, epc;
    logic impl, wa, ill, intr, trap;
    int code;
    logic [63:0] c, n;
    mip = (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_sw) << 3);
    impl = 1;
    case (csr_addr)
      12'h300: rd = m_mstatus;
      12'h304: rd = m_mie;
      12'h305: rd = m_mtvec;
      12'h340: rd = m_mscratch;
      12'h341: rd = m_mepc;
      12'h342: rd = m_mcause;
      12'h344: rd = mip;
      12'hB00: rd = m_cyc[31:0];
      12'hB80: rd = m_cyc[63:32];
      12'hB02: rd = m_ins[31:0];
      12'hB82: rd = m_ins[63:32];
      default: begin rd = 0; impl = 0; end
    endcase
    wa = csr_op == 1 || csr_wdata != 0;
    ill = csr_op != 0 && (!impl || (csr_addr == 12'h344 && wa));
    pend = mip & m_mie;
    intr = m_mstatus[3] && pend != 0;
    trap = exc_valid || mret || intr;
    code = pend[11] ? 11 : pend[3] ? 3 : 7;
    epc = exc_valid ? m_mtvec & ~32'd3 : mret ? m_mepc :
          (m_mtvec & ~32'd3) + (m_mtvec[1:0] == 2'b01 ? 32'(4 * code) : 32'd0);
    nv = csr_op == 1 ? csr_wdata : csr_op == 2 ? rd | csr_wdata : rd & ~csr_wdata;
    #1;
    chk("rdata", csr_rdata, rd);
    chk("illegal", 32'(csr_illegal), 32'(ill));
    chk("redirect", 32'(redirect), 32'(trap));
    if (trap) chk("redirect_pc", redirect_pc, epc);
    @(posedge clk); #1;
    c = m_cyc + 1;
    n = m_ins + 64'(instr_retire && !exc_valid);
    if (csr_op != 0 && !ill && wa && !trap)
      case (csr_addr)
        12'h300: m_mstatus = 32'h1800 | (nv & 32'h88);
        12'h304: m_mie = nv & 32'h888;
        12'h305: m_mtvec = nv & ~32'd2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'd3;
        12'h342: m_mcause = nv;
        12'hB00: c = {m_cyc[63:32], nv};
        12'hB80: c = {nv, m_cyc[31:0]};
        12'hB02: n = {m_ins[63:32], nv};
        12'hB82: n = {nv, m_ins[31:0]};
        default: ;
      endcase
    if (exc_valid || (!mret && intr)) begin
      m_mepc = (exc_valid ? exc_pc : next_pc) & ~32'd3;
      m_mcause = exc_valid ? 32'(exc_cause) : 32'h8000_0000 | 32'(code);
      m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
    end else if (mret)
      m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
    m_cyc = c;
    m_ins = n;
    csr_op = 0; exc_valid = 0; mret = 0; instr_retire = 0;
  endtask
  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr(0, a, 0);
    #1 chk(tag, csr_rdata, exp);
    step();
  endtask
  initial begin
    csr(1, 12'h7C0, 32'h1); exc_valid = 1;
    #3;
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_illegal", 32'(csr_illegal), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0; csr_op = 0; exc_valid = 0;
    model_reset();
    rd_chk("mstatus_rst", 12'h300, 32'h1800);
    rd_chk("mtvec_rst", 12'h305, 32'h0);
    csr(1, 12'h300, 32'hFFFF_FFFF); step();
    rd_chk("mstatus_rw", 12'h300, 32'h1888);
    csr(3, 12'h300, 32'h8); step();
    rd_chk("mstatus_rc", 12'h300, 32'h1880);
    csr(1, 12'h305, 32'h101); step();
    csr(1, 12'h304, 32'h800); step();
    csr(2, 12'h300, 32'h8); step();
    irq_ext = 1; next_pc = 32'h40;
    #1 chk("irq_redirect", 32'(redirect), 1);
    chk("irq_vec_pc", redirect_pc, 32'h12C);
    step();
    irq_ext = 0;
    rd_chk("irq_mepc", 12'h341, 32'h40);
    rd_chk("irq_mcause", 12'h342, 32'h8000_000B);
    rd_chk("irq_mstatus", 12'h300, 32'h1880);
    mret = 1;
    #1 chk("mret_pc", redirect_pc, 32'h40);
    step();
    rd_chk("mret_mstatus", 12'h300, 32'h1888);
    csr(1, 12'h340, 32'hA5A5_0000); step();
    exc_valid = 1; exc_cause = 2; exc_pc = 32'h80; mret = 1; csr(1, 12'h340, 32'h1234);
    #1 chk("exc_pc_base", redirect_pc, 32'h100);
    step();
    rd_chk("exc_mcause", 12'h342, 32'h2);
    rd_chk("exc_mscratch", 12'h340, 32'hA5A5_0000);
    rd_chk("exc_mepc", 12'h341, 32'h80);
    mret = 1;
    #1 chk("mret2_pc", redirect_pc, 32'h80);
    step();
    rd_chk("mret2_mstatus", 12'h300, 32'h1888);
    csr(1, 12'h304, 32'h888); step();
    irq_sw = 1; irq_timer = 1;
    #1 chk("prio_pc", redirect_pc, 32'h10C);
    step();
    irq_sw = 0; irq_timer = 0;
    rd_chk("prio_mcause", 12'h342, 32'h8000_0003);
    mret = 1; step();
    csr(1, 12'hB00, 32'hFFFF_FFFF); step();
    csr(1, 12'hB80, 32'hFFFF_FFFF); step();
    step();
    rd_chk("mcycle_wrap_lo", 12'hB00, 32'h0);
    rd_chk("mcycle_wrap_hi", 12'hB80, 32'h0);
    csr(1, 12'hB02, 0); step();
    csr(1, 12'hB82, 0); step();
    for (int i = 0; i < 5; i++) begin instr_retire = 1; step(); end
    rd_chk("minstret_5", 12'hB02, 32'h5);
    csr(1, 12'h344, 32'hFFFF);
    #1 chk("mip_rw_illegal", 32'(csr_illegal), 1);
    step();
    rd_chk("mie_kept", 12'h304, 32'h888);
    csr(2, 12'h344, 0);
    #1 chk("mip_rs0_legal", 32'(csr_illegal), 0);
    step();
    csr(1, 12'h7C0, 32'h5);
    #1 chk("unimpl_illegal", 32'(csr_illegal), 1);
    chk("unimpl_rdata", csr_rdata, 0);
    step();
    for (int i = 0; i < 400; i++) begin
      csr(2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 12)],
          $urandom_range(0, 3) == 0 ? 32'h0 : $urandom);
      exc_valid = $urandom_range(0, 9) == 0;
      mret = $urandom_range(0, 9) == 0;
      exc_cause = 4'($urandom);
      exc_pc = $urandom;
      next_pc = $urandom;
      irq_ext = $urandom_range(0, 3) == 0;
      irq_timer = $urandom_range(0, 3) == 0;
      irq_sw = $urandom_range(0, 3) == 0;
      instr_retire = 1'($urandom);
      step();
    end
    irq_ext = 0; irq_timer = 0; irq_sw = 0;
    csr(1, 12'h7C0, 32'h1); exc_valid = 1;
    rst = 1;
    #1 chk("midrst_redirect", 32'(redirect), 0);
    chk("midrst_illegal", 32'(csr_illegal), 0);
    @(posedge clk); #1;
    rst = 0; csr_op = 0; exc_valid = 0;
    model_reset();
    rd_chk("midrst_mstatus", 12'h300, 32'h1800);
    rd_chk("midrst_mcycle", 12'hB00, 32'h1);
    rd_chk("midrst_mepc", 12'h341, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_file_m.md
# csr_file_m

Parametrised machine-mode control/status register file for the rv32i core, successor to the fixed five-register CSR block. It sits beside the register file in the data path and decodes csrrw/csrrs/csrrc and their immediate forms. It sequences trap entry (exceptions and interrupts) and mret, and runs the mcycle/minstret counters. It outputs a redirect PC to the fetch stage.

## Interface
- XLEN, 32, data width of every CSR and data port
- CNT_W, 64, counter width; must satisfy XLEN < CNT_W ≤ 2*XLEN, with the upper part mapped to the "h" address
- MTVEC_RST, 32'h0000_0000, reset value of mtvec
- VECTORED_EN, 1, when 1, mtvec mode 01 vectors interrupts to base+4*cause; when 0, mode bit is read-only 0

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1 value or zero-extended uimm
- csr_rdata  out  XLEN  current (pre-write) value of the addressed CSR; 0 if unimplemented
- csr_illegal  out  1  access to an unimplemented address, or write to a read-only CSR
- exc_valid  in  1  synchronous exception this cycle
- exc_cause  in  4  exception code
- exc_pc  in  XLEN  PC of the faulting instruction
- mret  in  1  mret executing this cycle
- next_pc  in  XLEN  PC of the next instruction to execute; saved on an interrupt
- irq_ext, irq_timer, irq_sw  in  1 each  level-sensitive interrupt lines
- instr_retire  in  1  one instruction retired this cycle
- redirect  out  1  fetch must jump to redirect_pc
- redirect_pc  out  XLEN  trap vector or mepc

## Operation
- Address map:
  - mstatus 0x300
  - mie 0x304
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341
  - mcause 0x342
  - mip 0x344
  - mcycle 0xB00 / mcycleh 0xB80
  - minstret 0xB02 / minstreth 0xB82
- Write value: RW → wdata; RS → old|wdata; RC → old&~wdata.
- A write occurs when csr_op≠00, the address is legal, and not (RS/RC with wdata==0).
- RS/RC with wdata==0 is a pure read: a read-only CSR does not raise csr_illegal.
- Write masks:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads constant 11; all other bits read 0.
  - mie: only bits 3, 7 and 11 are writable.
  - mip: MSIP[3] = irq_sw; MTIP[7] = irq_timer; MEIP[11] = irq_ext. mip is read-only, so any write to it is illegal.
  - mepc: bits[1:0] read 0.
  - mtvec: bit1 reads 0; bit0 is writable only if VECTORED_EN.
  - mscratch and mcause: fully writable.
- When csr_illegal=1, no state changes.
- Interrupt pending: int_req = mstatus.MIE & |(mip & mie). Priority among pending sources: MEI(11) > MSI(3) > MTI(7).
- Event priority within a cycle: exc_valid > mret > interrupt. Only the winner acts.
- Whenever any trap or mret acts, the csr_op write is suppressed.
- Exception entry:
  - mepc ← exc_pc; mcause ← {0, exc_cause zero-extended}
  - MPIE ← MIE; MIE ← 0
  - redirect_pc = mtvec base (mtvec & ~3)
- Interrupt entry:
  - mepc ← next_pc; mcause ← {1, code}
  - MPIE ← MIE; MIE ← 0
  - redirect_pc = base + 4*code if mode=01, else base
- mret: MIE ← MPIE; MPIE ← 1; redirect_pc = mepc.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instr_retire=1, but not in a cycle where an exception is taken.
  - A CSR write to either half of a counter replaces that half with the written value. The counter does not increment in that cycle.
  - Both counters wrap 2^CNT_W−1 → 0.

## Timing
- csr_rdata, csr_illegal, redirect and redirect_pc are combinational in the same cycle as their inputs.
- All CSR updates take effect at the next rising edge, so a read in cycle N+1 sees a write made in cycle N.
- redirect is high for exactly the cycle in which the trap or mret acts.
- An interrupt remains requested while its line is high. Because MIE clears at entry, no re-entry occurs until mret.
- On rst assertion, mid-operation:
  - mstatus=0x1800; mie, mip-enable state, mepc, mcause, mscratch = 0; mtvec=MTVEC_RST; counters=0.
  - Outputs while in reset: redirect=0, csr_illegal=0.
  - A trap in progress is abandoned.

## Test plan
- Reset, then read 0x300 → 0x00001800; RW 0xFFFFFFFF to 0x300, read back → 0x00001888; RC 0x8 to 0x300 → 0x00001880.
- mtvec=0x101, mie=0x800, mstatus.MIE=1, pulse irq_ext with next_pc=0x40 → redirect=1, redirect_pc=0x12C; next cycle mepc=0x40, mcause=0x8000000B, mstatus=0x1880.
- In the same cycle: exc_valid (cause 2, pc 0x80), mret=1 and a csrrw to mscratch → redirect_pc=mtvec base, mcause=2, mscratch unchanged.
- mret after the trap above → redirect_pc=mepc, mstatus.MIE=1, MPIE=1.
- Counters:
  - Write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF, then one clock → both halves read 0.
  - instr_retire held for 5 cycles → minstret=5.
- Illegal accesses:
  - csrrw to 0x344 → csr_illegal=1, no state change.
  - csrrs x0 to 0x344 → csr_illegal=0.
  - Access to 0x7C0 → csr_illegal=1, csr_rdata=0.
